// File: rtl/nn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : nn_ctrl_pkg
//  Brief   : Shared constants and state encoding for the classifier frame
//            sequencer (nn_infer_ctrl) and its beat counters.
//  Revision: 1.0  initial release
// ============================================================================
package nn_ctrl_pkg;

    // Default geometry of the 10-neuron fully connected classifier
    localparam int DW_DEF        = 22;   // 6 integer + 16 fractional bits
    localparam int WIDTH_DEF     = 784;  // pixels per frame (28x28)
    localparam int DRAIN_CYC_DEF = 2;    // ROM read + MAC register
    localparam int CYC_W_DEF     = 16;

    // Counter widths derived from the default geometry
    localparam int PIX_CNT_W   = $clog2(WIDTH_DEF);
    localparam int DRAIN_CNT_W = $clog2(DRAIN_CYC_DEF + 1);

    // Sequencer state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CLEAR  = 3'd1;
    localparam state_t ST_STREAM = 3'd2;
    localparam state_t ST_DRAIN  = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

endpackage : nn_ctrl_pkg
`default_nettype wire

// File: rtl/nn_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module  : nn_beat_counter
//  Brief   : Modulo-N up-counter with synchronous clear, count enable and a
//            terminal-count flag that is high while the count equals N-1.
//  Revision: 1.0  initial release
// ============================================================================
module nn_beat_counter #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_o = (cnt_q == LAST);

    // Next count: clear wins over enable; wrap to zero after the last value
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : nn_beat_counter
`default_nettype wire

// File: rtl/nn_infer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : nn_infer_ctrl
//  Brief   : Frame sequencer for the 10-neuron classifier. Clears the
//            datapath, streams one frame of pixels with one enable per
//            accepted beat, waits out pipeline latency and holds the
//            predicted class until the consumer takes it.
//  Revision: 1.0  initial release
// ============================================================================
module nn_infer_ctrl
    import nn_ctrl_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF,
    parameter int CYC_W     = CYC_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [DW-1:0]    pix_data,
    output logic             nn_rst,
    output logic             nn_en,
    output logic [DW-1:0]    nn_pix,
    input  logic [DW-1:0]    nn_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [DW-1:0]    res_data,
    output logic [CYC_W-1:0] res_cycles
);

    localparam int              PIX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int              DRN_W   = $clog2(DRAIN_CYC + 1);
    localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};

    state_t           state_q;
    state_t           state_d;
    logic             res_valid_q;
    logic             res_valid_d;
    logic [DW-1:0]    res_data_q;
    logic [DW-1:0]    res_data_d;
    logic [CYC_W-1:0] res_cycles_q;
    logic [CYC_W-1:0] res_cycles_d;
    logic [CYC_W-1:0] cyc_q;
    logic [CYC_W-1:0] cyc_d;
    logic [CYC_W-1:0] cyc_inc;

    logic             in_clear;
    logic             in_stream;
    logic             in_drain;
    logic             beat;
    logic             pix_tc;
    logic             drain_tc;
    logic             drain_last;
    logic             res_take;

    assign in_clear   = (state_q == ST_CLEAR);
    assign in_stream  = (state_q == ST_STREAM);
    assign in_drain   = (state_q == ST_DRAIN);
    assign beat       = in_stream & pix_valid;
    assign drain_last = in_drain & drain_tc;
    assign res_take   = res_valid_q & res_ready;

    // Saturating increment keeps very long stalled frames from wrapping
    assign cyc_inc    = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + CYC_W'(1);

    assign busy       = (state_q != ST_IDLE);
    assign pix_ready  = in_stream;
    assign nn_en      = beat;
    assign nn_pix     = pix_data;
    assign nn_rst     = reset | in_clear;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_cycles = res_cycles_q;

    // Pixel position within the frame; cleared together with the datapath
    nn_beat_counter #(
        .N (WIDTH),
        .W (PIX_W)
    ) u_pix_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (in_clear),
        .en_i  (beat),
        .tc_o  (pix_tc)
    );

    // Pipeline drain timer
    nn_beat_counter #(
        .N (DRAIN_CYC),
        .W (DRN_W)
    ) u_drain_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (in_clear),
        .en_i  (in_drain),
        .tc_o  (drain_tc)
    );

    // Sequencer next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start)           state_d = ST_CLEAR;
            ST_CLEAR:                       state_d = ST_STREAM;
            ST_STREAM: if (beat && pix_tc)  state_d = ST_DRAIN;
            ST_DRAIN:  if (drain_tc)        state_d = ST_DONE;
            ST_DONE:   if (res_take)        state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    // Cycle counter and result register next values; the captured cycle
    // count includes the final drain cycle itself
    always_comb begin
        cyc_d        = cyc_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_cycles_d = res_cycles_q;
        if ((state_q == ST_IDLE) && start) begin
            cyc_d = '0;
        end else if (in_clear || in_stream || in_drain) begin
            cyc_d = cyc_inc;
        end
        if (drain_last) begin
            res_valid_d  = 1'b1;
            res_data_d   = nn_result;
            res_cycles_d = cyc_inc;
        end else if (res_take) begin
            res_valid_d  = 1'b0;
        end
    end

    // State, cycle counter and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cyc_q        <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_cycles_q <= res_cycles_d;
        end
    end

endmodule : nn_infer_ctrl
`default_nettype wire

// File: tb/tb_nn_infer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_nn_infer_ctrl
//  Brief   : Directed self-checking bench for nn_infer_ctrl.
//  Revision: 1.0  initial release
// ============================================================================
module tb_nn_infer_ctrl;

    localparam int DW = 22;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          pix_valid;
    logic          pix_ready;
    logic [DW-1:0] pix_data;
    logic          nn_rst;
    logic          nn_en;
    logic [DW-1:0] nn_pix;
    logic [DW-1:0] nn_result;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic [15:0]   res_cycles;

    int errors = 0;
    int checks = 0;

    // Pixel-stream monitor state
    int en_cnt    = 0;
    int rst_cnt   = 0;
    int order_err = 0;
    int exp_idx   = 0;

    nn_infer_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .nn_rst     (nn_rst),
        .nn_en      (nn_en),
        .nn_pix     (nn_pix),
        .nn_result  (nn_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_cycles (res_cycles)
    );

    always #5 clk = ~clk;

    // Pixels must reach the datapath in order 0,1,2,... after each clear
    always @(posedge clk) begin
        if (nn_rst) exp_idx <= 0;
        if (nn_rst && !reset) rst_cnt <= rst_cnt + 1;
        if (nn_en) begin
            en_cnt  <= en_cnt + 1;
            exp_idx <= exp_idx + 1;
            if (nn_pix !== DW'(exp_idx)) order_err <= order_err + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start a frame and feed pixels until res_valid, a beat limit, or timeout.
    // lat counts cycles from the CLEAR cycle; nst counts STREAM cycles without a beat.
    task automatic run_frame(input logic [DW-1:0] res, input bit stall, input bit mid_start,
                             input int stop_at, output int lat, output int nst);
        int idx;
        int cyc;
        nn_result = res;
        idx = 0; cyc = 0; lat = 0; nst = 0;
        @(negedge clk);
        start = 1'b1; pix_valid = 1'b1; pix_data = '0;
        @(negedge clk);
        start = 1'b0;
        while (res_valid !== 1'b1 && lat < 5000 && idx != stop_at) begin
            pix_valid = stall ? ((cyc % 3) != 2) : 1'b1;
            pix_data  = DW'(idx);
            start     = mid_start && (idx == 100);
            #1;
            if (pix_ready === 1'b1 && pix_valid) idx++;
            else if (pix_ready === 1'b1) nst++;
            cyc++;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        pix_valid = 1'b0;
    endtask

    // Consumer takes the result, optionally with start high at the same time
    task automatic take_result(input bit with_start, input string tag);
        res_ready = 1'b1;
        start = with_start;
        @(negedge clk);
        res_ready = 1'b0;
        start = 1'b0;
        check({tag, "_rv_clr"}, res_valid, 0);
        check({tag, "_idle"}, busy, 0);
        @(negedge clk);
        check({tag, "_stay_idle"}, busy, 0);
    endtask

    initial begin
        int lat;
        int nst;
        int en0;
        int rs0;
        reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = '0;
        nn_result = '0; res_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_nn_en", nn_en, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_nn_rst", nn_rst, 1);
        check("rst_res_data", res_data, 0);
        check("rst_res_cycles", res_cycles, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_nn_rst", nn_rst, 0);
        check("idle_busy", busy, 0);

        // Frame A: no stalls, prediction 3, then 10 cycles of backpressure
        en0 = en_cnt; rs0 = rst_cnt;
        run_frame(22'h3, 1'b0, 1'b0, -1, lat, nst);
        check("A_latency", lat, 787);
        check("A_res_valid", res_valid, 1);
        check("A_res_data", res_data, 3);
        check("A_res_cycles", res_cycles, 787);
        check("A_en_pulses", en_cnt - en0, 784);
        check("A_rst_pulses", rst_cnt - rs0, 1);
        check("A_order", order_err, 0);
        check("A_done_nn_en", nn_en, 0);
        for (int i = 0; i < 10; i++) begin
            nn_result = 22'h3FF;
            pix_valid = 1'b1;
            @(negedge clk);
            check("bp_res_data", res_data, 3);
            check("bp_res_cycles", res_cycles, 787);
            check("bp_pix_ready", pix_ready, 0);
            check("bp_busy", busy, 1);
            check("bp_res_valid", res_valid, 1);
        end
        pix_valid = 1'b0;
        take_result(1'b0, "A");

        // Frame B: pix_valid low every 3rd cycle -> 392 stall cycles, 1179 total
        en0 = en_cnt; rs0 = rst_cnt;
        run_frame(22'h5, 1'b1, 1'b0, -1, lat, nst);
        check("B_stalls", nst, 392);
        check("B_latency", lat, 1179);
        check("B_res_cycles", res_cycles, 1179);
        check("B_res_data", res_data, 5);
        check("B_en_pulses", en_cnt - en0, 784);
        check("B_rst_pulses", rst_cnt - rs0, 1);
        check("B_order", order_err, 0);
        // start high together with the handshake in DONE is ignored
        take_result(1'b1, "B");

        // Reset after 400 accepted pixels
        en0 = en_cnt;
        run_frame(22'h9, 1'b0, 1'b0, 400, lat, nst);
        check("R_partial_beats", en_cnt - en0, 400);
        check("R_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check("R_nn_rst_now", nn_rst, 1);
        @(negedge clk);
        check("R_busy", busy, 0);
        check("R_nn_rst", nn_rst, 1);
        check("R_res_valid", res_valid, 0);
        reset = 1'b0;
        @(negedge clk);
        check("R_nn_rst_rel", nn_rst, 0);
        check("R_idle", busy, 0);

        // Frame C: full frame after reset, start pulsed mid-stream is ignored
        en0 = en_cnt; rs0 = rst_cnt;
        run_frame(22'h7, 1'b0, 1'b1, -1, lat, nst);
        check("C_latency", lat, 787);
        check("C_res_data", res_data, 7);
        check("C_res_cycles", res_cycles, 787);
        check("C_en_pulses", en_cnt - en0, 784);
        check("C_rst_pulses", rst_cnt - rs0, 1);
        check("C_order", order_err, 0);
        take_result(1'b0, "C");

        // Frame D: back-to-back with a different prediction
        en0 = en_cnt; rs0 = rst_cnt;
        run_frame(22'h2, 1'b0, 1'b0, -1, lat, nst);
        check("D_latency", lat, 787);
        check("D_res_data", res_data, 2);
        check("D_en_pulses", en_cnt - en0, 784);
        check("D_rst_pulses", rst_cnt - rs0, 1);
        check("D_order", order_err, 0);
        take_result(1'b0, "D");
        check("D_res_data_kept", res_data, 2);
        check("D_res_cycles_kept", res_cycles, 787);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_nn_infer_ctrl
`default_nettype wire
